// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order instruction-memory requests, buffers
// the responses with their PCs and presents one {pc, inst} per cycle to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_f_pc,
  output logic [31:0] o_f_inst,
  output logic        o_f_valid
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FQ_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  fq_entry_t     fq_q [FQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rpc_q, rpc_d;

  logic [CW:0]   in_use;
  logic [31:0]   target_pc;
  logic          fire, rsp_live, empty, pop, push;
  logic [1:0]    unused_pc_lsbs;

  assign unused_pc_lsbs = i_redirect_pc[1:0];
  assign target_pc      = {i_redirect_pc[31:2], 2'b00};

  // Capacity counts only responses that will actually land in the queue.
  assign in_use     = {1'b0, count_q} + {1'b0, out_q - drop_q};
  assign o_imem_req = !rst && !i_redirect && (in_use < DEPTH_C);
  assign o_imem_addr = pc_q;

  assign fire     = o_imem_req && i_imem_gnt;
  assign rsp_live = i_imem_rvalid && (out_q != '0);
  assign empty    = (count_q == '0);
  assign pop      = !i_stall && !empty && !i_redirect;
  assign push     = rsp_live && (drop_q == '0) && !i_redirect;

  assign o_f_valid = !empty && !i_redirect;
  assign o_f_pc    = o_f_valid ? fq_q[rd_ptr_q].pc   : rpc_q;
  assign o_f_inst  = o_f_valid ? fq_q[rd_ptr_q].inst : NOP_INST;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    pc_d     = pc_q;
    rpc_d    = rpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    drop_d   = drop_q;

    if (i_redirect) begin
      pc_d     = target_pc;
      rpc_d    = target_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      out_d    = out_q - CW'(rsp_live);
      // Everything still in flight after this cycle belongs to the old path.
      drop_d   = out_d;
    end else begin
      if (fire) pc_d = pc_q + 32'd4;
      out_d = out_q + CW'(fire) - CW'(rsp_live);
      if (rsp_live && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rpc_d    = rpc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      pc_q     <= RESET_PC;
      rpc_q    <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rpc_q    <= rpc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) fq_q[wr_ptr_q] <= '{pc: rpc_q, inst: i_imem_rdata};
  end

endmodule
